alarm_scheduler: RTL and testbench

- Multi-slot alarm scheduler. Holds N_SLOTS alarm times programmed from the UART command decoder and compares them against the RTC once per second.
- Arbitrates simultaneous or overlapping alarms by fixed priority and sequences a single buzzer output through ring, snooze and dismiss.
- Sits between the RTC counter, the UART register writer, the user button inputs and the buzzer/LED driver.

---
 rtl/alarm_scheduler.sv | 153 +++++++++++++++
 tb/tb_alarm_scheduler.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alarm_scheduler.sv
// Multi-slot alarm scheduler: compares programmed slot times against the RTC once
// per second and sequences a single buzzer through ring, snooze and dismiss.
module alarm_scheduler #(
    parameter int N_SLOTS          = 4,
    parameter int SLOT_W           = 2,
    parameter int SNOOZE_SEC       = 300,
    parameter int RING_TIMEOUT_SEC = 60
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [4:0]          hour_rtc,
    input  logic [5:0]          min_rtc,
    input  logic [5:0]          sec_rtc,
    input  logic                wr_en,
    input  logic [SLOT_W-1:0]   wr_slot,
    input  logic [4:0]          wr_hour,
    input  logic [5:0]          wr_min,
    input  logic [5:0]          wr_sec,
    input  logic                wr_arm,
    input  logic                dismiss,
    input  logic                snooze,
    output logic                ring,
    output logic [SLOT_W-1:0]   active_slot,
    output logic [N_SLOTS-1:0]  armed,
    output logic [N_SLOTS-1:0]  pending,
    output logic [1:0]          state
);

    localparam logic [1:0] S_IDLE   = 2'b00;
    localparam logic [1:0] S_RING   = 2'b01;
    localparam logic [1:0] S_SNOOZE = 2'b10;

    localparam logic [8:0] SNOOZE_LOAD = 9'(SNOOZE_SEC);
    localparam logic [8:0] RING_LOAD   = 9'(RING_TIMEOUT_SEC);

    logic [4:0] slot_hour [N_SLOTS];
    logic [5:0] slot_min  [N_SLOTS];
    logic [5:0] slot_sec  [N_SLOTS];

    logic [5:0] prev_sec;
    logic [8:0] ring_cnt;
    logic [8:0] snz_cnt;

    logic               tick;
    logic               wr_valid;
    logic               cancel_active;
    logic [N_SLOTS-1:0] match_vec;
    logic [N_SLOTS-1:0] clr_vec;
    logic [N_SLOTS-1:0] pending_next;
    logic [SLOT_W-1:0]  first_pending;
    logic [1:0]         state_next;
    logic [SLOT_W-1:0]  active_next;
    logic [8:0]         ring_cnt_next;
    logic [8:0]         snz_cnt_next;
    logic               ring_next;

    // Matching, pending bookkeeping and slot selection. IDLE looks at the pending
    // set including this cycle's matches so the buzzer starts two cycles after a tick.
    always_comb begin
        tick          = (sec_rtc != prev_sec);
        wr_valid      = wr_en && ({{(32-SLOT_W){1'b0}}, wr_slot} < 32'(N_SLOTS));
        cancel_active = wr_valid && !wr_arm && (wr_slot == active_slot) && (state != S_IDLE);

        for (int i = 0; i < N_SLOTS; i++) begin
            match_vec[i] = tick && armed[i] &&
                           (slot_hour[i] == hour_rtc) &&
                           (slot_min[i]  == min_rtc)  &&
                           (slot_sec[i]  == sec_rtc);
            clr_vec[i]   = (wr_valid && !wr_arm && (wr_slot == SLOT_W'(i))) ||
                           (dismiss && (state != S_IDLE) && (active_slot == SLOT_W'(i)));
        end

        pending_next = (pending | match_vec) & ~clr_vec;

        first_pending = '0;
        for (int i = N_SLOTS - 1; i >= 0; i--) begin
            if (pending_next[i]) first_pending = SLOT_W'(i);
        end
    end

    // Ring / snooze sequencer. Counters only move on second ticks and exit their
    // state on the tick that takes them to zero.
    always_comb begin
        state_next    = state;
        active_next   = active_slot;
        ring_cnt_next = ring_cnt;
        snz_cnt_next  = snz_cnt;

        case (state)
            S_IDLE: begin
                if (|pending_next) begin
                    state_next    = S_RING;
                    active_next   = first_pending;
                    ring_cnt_next = RING_LOAD;
                end
            end
            S_RING: begin
                if (tick && ring_cnt != 9'd0) ring_cnt_next = ring_cnt - 9'd1;
                if (cancel_active || dismiss) begin
                    state_next = S_IDLE;
                end else if (snooze || (tick && ring_cnt == 9'd1)) begin
                    state_next   = S_SNOOZE;
                    snz_cnt_next = SNOOZE_LOAD;
                end
            end
            S_SNOOZE: begin
                if (tick && snz_cnt != 9'd0) snz_cnt_next = snz_cnt - 9'd1;
                if (cancel_active || dismiss) begin
                    state_next = S_IDLE;
                end else if (tick && snz_cnt == 9'd1) begin
                    state_next    = S_RING;
                    ring_cnt_next = RING_LOAD;
                end
            end
            default: state_next = S_IDLE;
        endcase

        ring_next = (state == S_RING) && (state_next == S_RING);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_SLOTS; i++) begin
                slot_hour[i] <= '0;
                slot_min[i]  <= '0;
                slot_sec[i]  <= '0;
            end
            armed       <= '0;
            pending     <= '0;
            state       <= S_IDLE;
            active_slot <= '0;
            ring        <= 1'b0;
            ring_cnt    <= '0;
            snz_cnt     <= '0;
            prev_sec    <= '0;
        end else begin
            if (tick) prev_sec <= sec_rtc;
            if (wr_valid) begin
                slot_hour[wr_slot] <= wr_hour;
                slot_min[wr_slot]  <= wr_min;
                slot_sec[wr_slot]  <= wr_sec;
                armed[wr_slot]     <= wr_arm;
            end
            pending     <= pending_next;
            state       <= state_next;
            active_slot <= active_next;
            ring        <= ring_next;
            ring_cnt    <= ring_cnt_next;
            snz_cnt     <= snz_cnt_next;
        end
    end

endmodule

// File: tb/tb_alarm_scheduler.sv
// Directed bench for alarm_scheduler: each task drives one scenario and checks
// the buzzer, state and slot bookkeeping against hand-derived values.
module tb_alarm_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] hour_rtc;
    logic [5:0] min_rtc;
    logic [5:0] sec_rtc;
    logic       wr_en;
    logic [1:0] wr_slot;
    logic [4:0] wr_hour;
    logic [5:0] wr_min;
    logic [5:0] wr_sec;
    logic       wr_arm;
    logic       dismiss;
    logic       snooze;
    logic       ring;
    logic [1:0] active_slot;
    logic [3:0] armed;
    logic [3:0] pending;
    logic [1:0] state;

    int compared = 0;
    int mismatched = 0;

    alarm_scheduler dut (
        .clk(clk), .rst(rst),
        .hour_rtc(hour_rtc), .min_rtc(min_rtc), .sec_rtc(sec_rtc),
        .wr_en(wr_en), .wr_slot(wr_slot), .wr_hour(wr_hour), .wr_min(wr_min),
        .wr_sec(wr_sec), .wr_arm(wr_arm),
        .dismiss(dismiss), .snooze(snooze),
        .ring(ring), .active_slot(active_slot), .armed(armed),
        .pending(pending), .state(state)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_time(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
        hour_rtc = h;
        min_rtc  = m;
        sec_rtc  = s;
        cyc(1);
    endtask

    task automatic write_slot(input logic [1:0] slot, input logic [4:0] h, input logic [5:0] m,
                              input logic [5:0] s, input logic arm);
        wr_en = 1'b1; wr_slot = slot; wr_hour = h; wr_min = m; wr_sec = s; wr_arm = arm;
        cyc(1);
        wr_en = 1'b0;
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) begin
            sec_rtc = (sec_rtc == 6'd59) ? 6'd0 : sec_rtc + 6'd1;
            cyc(1);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
        compared++;
        if (state !== 2'b00) begin mismatched++; $display("[TB] FAIL reset_state got %b want 00", state); end
        compared++;
        if (ring !== 1'b0 || active_slot !== 2'd0) begin
            mismatched++; $display("[TB] FAIL reset_ring got ring=%b slot=%0d want 0/0", ring, active_slot);
        end
        compared++;
        if (armed !== 4'b0000 || pending !== 4'b0000) begin
            mismatched++; $display("[TB] FAIL reset_bits got armed=%b pending=%b want 0000/0000", armed, pending);
        end
    endtask

    task automatic test_single_alarm;
        write_slot(2'd0, 5'd7, 6'd30, 6'd0, 1'b1);
        compared++;
        if (armed !== 4'b0001) begin mismatched++; $display("[TB] FAIL write_armed got %b want 0001", armed); end
        set_time(5'd7, 6'd29, 6'd59);
        compared++;
        if (state !== 2'b00 || ring !== 1'b0) begin
            mismatched++; $display("[TB] FAIL pre_match got state=%b ring=%b want 00/0", state, ring);
        end
        set_time(5'd7, 6'd30, 6'd0);
        compared++;
        if (state !== 2'b01 || ring !== 1'b0) begin
            mismatched++; $display("[TB] FAIL match_cycle1 got state=%b ring=%b want 01/0", state, ring);
        end
        cyc(1);
        compared++;
        if (ring !== 1'b1 || active_slot !== 2'd0 || pending !== 4'b0001) begin
            mismatched++;
            $display("[TB] FAIL match_cycle2 got ring=%b slot=%0d pending=%b want 1/0/0001", ring, active_slot, pending);
        end
    endtask

    task automatic test_snooze;
        hour_rtc = 5'd8;
        snooze = 1'b1;
        cyc(1);
        snooze = 1'b0;
        compared++;
        if (state !== 2'b10 || ring !== 1'b0) begin
            mismatched++; $display("[TB] FAIL snooze_enter got state=%b ring=%b want 10/0", state, ring);
        end
        snooze = 1'b1;
        tick_n(299);
        snooze = 1'b0;
        compared++;
        if (state !== 2'b10 || ring !== 1'b0) begin
            mismatched++; $display("[TB] FAIL snooze_299 got state=%b ring=%b want 10/0", state, ring);
        end
        tick_n(1);
        compared++;
        if (state !== 2'b01) begin mismatched++; $display("[TB] FAIL snooze_expire got state=%b want 01", state); end
        cyc(1);
        compared++;
        if (ring !== 1'b1 || active_slot !== 2'd0) begin
            mismatched++; $display("[TB] FAIL snooze_rering got ring=%b slot=%0d want 1/0", ring, active_slot);
        end
        dismiss = 1'b1;
        cyc(1);
        dismiss = 1'b0;
        compared++;
        if (state !== 2'b00 || pending !== 4'b0000 || ring !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL snooze_dismiss got state=%b pending=%b ring=%b want 00/0000/0", state, pending, ring);
        end
        cyc(1);
    endtask

    task automatic test_overlap;
        write_slot(2'd1, 5'd12, 6'd0, 6'd0, 1'b1);
        write_slot(2'd3, 5'd12, 6'd0, 6'd0, 1'b1);
        set_time(5'd11, 6'd59, 6'd59);
        set_time(5'd12, 6'd0, 6'd0);
        compared++;
        if (pending !== 4'b1010 || active_slot !== 2'd1 || state !== 2'b01) begin
            mismatched++;
            $display("[TB] FAIL overlap_first got pending=%b slot=%0d state=%b want 1010/1/01", pending, active_slot, state);
        end
        cyc(1);
        compared++;
        if (ring !== 1'b1) begin mismatched++; $display("[TB] FAIL overlap_ring1 got %b want 1", ring); end
        dismiss = 1'b1;
        cyc(1);
        dismiss = 1'b0;
        compared++;
        if (state !== 2'b00 || pending !== 4'b1000 || ring !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL overlap_dismiss got state=%b pending=%b ring=%b want 00/1000/0", state, pending, ring);
        end
        cyc(1);
        compared++;
        if (state !== 2'b01 || active_slot !== 2'd3) begin
            mismatched++; $display("[TB] FAIL overlap_second got state=%b slot=%0d want 01/3", state, active_slot);
        end
        cyc(1);
        compared++;
        if (ring !== 1'b1) begin mismatched++; $display("[TB] FAIL overlap_ring3 got %b want 1", ring); end
        dismiss = 1'b1;
        cyc(1);
        dismiss = 1'b0;
        compared++;
        if (state !== 2'b00 || pending !== 4'b0000) begin
            mismatched++; $display("[TB] FAIL overlap_done got state=%b pending=%b want 00/0000", state, pending);
        end
    endtask

    task automatic test_timeout;
        write_slot(2'd2, 5'd13, 6'd0, 6'd0, 1'b1);
        set_time(5'd12, 6'd59, 6'd59);
        set_time(5'd13, 6'd0, 6'd0);
        cyc(1);
        compared++;
        if (ring !== 1'b1 || active_slot !== 2'd2) begin
            mismatched++; $display("[TB] FAIL timeout_start got ring=%b slot=%0d want 1/2", ring, active_slot);
        end
        hour_rtc = 5'd14;
        tick_n(59);
        compared++;
        if (state !== 2'b01 || ring !== 1'b1) begin
            mismatched++; $display("[TB] FAIL timeout_59 got state=%b ring=%b want 01/1", state, ring);
        end
        tick_n(1);
        compared++;
        if (state !== 2'b10 || ring !== 1'b0) begin
            mismatched++; $display("[TB] FAIL timeout_auto got state=%b ring=%b want 10/0", state, ring);
        end
        tick_n(299);
        compared++;
        if (state !== 2'b10) begin mismatched++; $display("[TB] FAIL timeout_snz299 got %b want 10", state); end
        tick_n(1);
        compared++;
        if (state !== 2'b01) begin mismatched++; $display("[TB] FAIL timeout_snz300 got %b want 01", state); end
        cyc(1);
    endtask

    task automatic test_disarm_active;
        compared++;
        if (ring !== 1'b1 || active_slot !== 2'd2) begin
            mismatched++; $display("[TB] FAIL disarm_pre got ring=%b slot=%0d want 1/2", ring, active_slot);
        end
        write_slot(2'd2, 5'd13, 6'd0, 6'd0, 1'b0);
        compared++;
        if (state !== 2'b00 || ring !== 1'b0 || pending !== 4'b0000 || armed !== 4'b1011) begin
            mismatched++;
            $display("[TB] FAIL disarm_active got state=%b ring=%b pending=%b armed=%b want 00/0/0000/1011",
                     state, ring, pending, armed);
        end
    endtask

    task automatic test_dismiss_and_snooze;
        set_time(5'd7, 6'd29, 6'd59);
        set_time(5'd7, 6'd30, 6'd0);
        cyc(1);
        dismiss = 1'b1;
        snooze  = 1'b1;
        cyc(1);
        dismiss = 1'b0;
        snooze  = 1'b0;
        compared++;
        if (state !== 2'b00 || ring !== 1'b0 || pending !== 4'b0000) begin
            mismatched++;
            $display("[TB] FAIL dismiss_wins got state=%b ring=%b pending=%b want 00/0/0000", state, ring, pending);
        end
    endtask

    task automatic test_dismiss_held;
        dismiss = 1'b1;
        set_time(5'd7, 6'd29, 6'd58);
        set_time(5'd7, 6'd30, 6'd0);
        compared++;
        if (state !== 2'b01) begin mismatched++; $display("[TB] FAIL held_enter got %b want 01", state); end
        cyc(1);
        compared++;
        if (state !== 2'b00 || ring !== 1'b0 || pending !== 4'b0000 || armed[0] !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL held_exit got state=%b ring=%b pending=%b armed=%b want 00/0/0000/xxx1",
                     state, ring, pending, armed);
        end
        dismiss = 1'b0;
        cyc(1);
    endtask

    task automatic test_rollover_and_reset;
        write_slot(2'd3, 5'd0, 6'd0, 6'd0, 1'b1);
        set_time(5'd23, 6'd59, 6'd59);
        set_time(5'd0, 6'd0, 6'd0);
        compared++;
        if (state !== 2'b01 || active_slot !== 2'd3) begin
            mismatched++; $display("[TB] FAIL rollover got state=%b slot=%0d want 01/3", state, active_slot);
        end
        cyc(1);
        snooze = 1'b1;
        cyc(1);
        snooze = 1'b0;
        compared++;
        if (state !== 2'b10) begin mismatched++; $display("[TB] FAIL rollover_snooze got %b want 10", state); end
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        compared++;
        if (armed !== 4'b0000 || state !== 2'b00 || ring !== 1'b0 || pending !== 4'b0000) begin
            mismatched++;
            $display("[TB] FAIL mid_reset got armed=%b state=%b ring=%b pending=%b want 0000/00/0/0000",
                     armed, state, ring, pending);
        end
    endtask

    initial begin
        rst = 1'b1;
        hour_rtc = '0; min_rtc = '0; sec_rtc = '0;
        wr_en = 1'b0; wr_slot = '0; wr_hour = '0; wr_min = '0; wr_sec = '0; wr_arm = 1'b0;
        dismiss = 1'b0; snooze = 1'b0;
        #1;
        test_reset();
        test_single_alarm();
        test_snooze();
        test_overlap();
        test_timeout();
        test_disarm_active();
        test_dismiss_and_snooze();
        test_dismiss_held();
        test_rollover_and_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
